// File: rtl/chess_pkg.sv
// Shared chessboard types, geometry constants and the start-position layout.
package chess_pkg;

   localparam int SQ_PX    = 55;
   localparam int BOARD_SQ = 8;

   typedef enum logic [3:0] {
      EMPTY    = 4'd0,
      W_PAWN   = 4'd1,
      W_KNIGHT = 4'd2,
      W_BISHOP = 4'd3,
      W_ROOK   = 4'd4,
      W_QUEEN  = 4'd5,
      W_KING   = 4'd6,
      B_PAWN   = 4'd7,
      B_KNIGHT = 4'd8,
      B_BISHOP = 4'd9,
      B_ROOK   = 4'd10,
      B_QUEEN  = 4'd11,
      B_KING   = 4'd12
   } piece_t;

   typedef logic [5:0] sq_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      COMMIT = 2'd2
   } arb_state_t;

   // Square index is {row, col}; black back rank sits on row 0 (top of screen).
   function automatic piece_t start_piece(input sq_t sq);
      piece_t     p;
      logic [2:0] r;
      logic [2:0] c;
      r = sq[5:3];
      c = sq[2:0];
      p = EMPTY;
      case (r)
         3'd0: case (c)
                  3'd0, 3'd7: p = B_ROOK;
                  3'd1, 3'd6: p = B_KNIGHT;
                  3'd2, 3'd5: p = B_BISHOP;
                  3'd3:       p = B_QUEEN;
                  default:    p = B_KING;
               endcase
         3'd1: p = B_PAWN;
         3'd6: p = W_PAWN;
         3'd7: case (c)
                  3'd0, 3'd7: p = W_ROOK;
                  3'd1, 3'd6: p = W_KNIGHT;
                  3'd2, 3'd5: p = W_BISHOP;
                  3'd3:       p = W_QUEEN;
                  default:    p = W_KING;
               endcase
         default: p = EMPTY;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/board_store.sv
// 64x4 board register file: combinational read, one write port, synchronous
// reload of the start position (load_start wins over a write).
module board_store
   import chess_pkg::*;
(
   input  logic       clk,
   input  logic       load_start,
   input  logic       we,
   input  sq_t        wr_addr,
   input  logic [3:0] wr_data,
   input  sq_t        rd_addr,
   output logic [3:0] rd_data
);

   logic [63:0][3:0] mem_q;
   logic [63:0][3:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      if (load_start) begin
         for (int i = 0; i < 64; i++) mem_d[i] = start_piece(sq_t'(i));
      end else if (we) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/board_sprite_sched.sv
// Per-pixel chessboard sprite scheduler: beam-to-square tracking, sprite
// select/address generation and tear-free arbitration of board-store writes.
module board_sprite_sched
   import chess_pkg::*;
#(
   parameter int BOARD_X0 = 100,
   parameter int BOARD_Y0 = 20,
   parameter int SQ       = SQ_PX,
   parameter int V_ACTIVE = 480
)(
   input  logic        vga_clk,
   input  logic        reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        wr_req,
   input  logic [5:0]  wr_sq,
   input  logic [3:0]  wr_piece,
   input  logic        clr_req,
   output logic        wr_ack,
   output logic [3:0]  sprite_sel,
   output logic [11:0] sprite_addr,
   output logic        piece_on,
   output logic        board_on,
   output logic        square_dark,
   output logic        frame_busy
);

   localparam int BOARD_PX = BOARD_SQ * SQ;

   logic [2:0]  col_q, col_d, row_q, row_d;
   logic [5:0]  offx_q, offx_d, offy_q, offy_d;
   logic        xin_q, xin_d, yin_q, yin_d;
   logic [11:0] ybase_q, ybase_d;

   logic [3:0]  sprite_sel_q, sprite_sel_d;
   logic [11:0] sprite_addr_q, sprite_addr_d;
   logic        piece_on_q, piece_on_d;
   logic        board_on_q, board_on_d;
   logic        square_dark_q, square_dark_d;
   logic        frame_busy_q, frame_busy_d;
   logic        wr_ack_q, wr_ack_d;

   arb_state_t  state_q, state_d;
   logic        store_we, store_clr;
   logic [3:0]  rd_piece;
   logic        line_start, in_rows;

   assign line_start = (DrawX == 10'd0);
   assign in_rows    = (DrawY >= 10'(BOARD_Y0)) && (DrawY <= 10'(BOARD_Y0 + BOARD_PX - 1));

   // Beam trackers. Outputs are built from the next-state values so the
   // scheduler adds exactly one cycle of latency from DrawX/DrawY.
   always_comb begin
      col_d   = col_q;
      offx_d  = offx_q;
      xin_d   = xin_q;
      row_d   = row_q;
      offy_d  = offy_q;
      yin_d   = yin_q;
      ybase_d = ybase_q;

      if (DrawX == 10'(BOARD_X0)) begin
         col_d  = '0;
         offx_d = '0;
         xin_d  = 1'b1;
      end else if (xin_q) begin
         if (offx_q == 6'(SQ - 1)) begin
            offx_d = '0;
            if (col_q == 3'd7) xin_d = 1'b0;
            else               col_d = col_q + 3'd1;
         end else begin
            offx_d = offx_q + 6'd1;
         end
      end

      if (line_start) begin
         if (DrawY >= 10'(V_ACTIVE)) begin
            yin_d = 1'b0;
         end else if (DrawY == 10'(BOARD_Y0)) begin
            row_d  = '0;
            offy_d = '0;
            yin_d  = 1'b1;
         end else if (yin_q) begin
            if (offy_q == 6'(SQ - 1)) begin
               offy_d = '0;
               if (row_q == 3'd7) yin_d = 1'b0;
               else               row_d = row_q + 3'd1;
            end else begin
               offy_d = offy_q + 6'd1;
            end
         end
         ybase_d = 12'(offy_d) * 12'(SQ);
      end
   end

   always_comb begin
      board_on_d    = xin_d & yin_d;
      sprite_sel_d  = board_on_d ? rd_piece : 4'd0;
      piece_on_d    = board_on_d & (sprite_sel_d != 4'd0);
      sprite_addr_d = board_on_d ? (ybase_d + 12'(offx_d)) : 12'd0;
      square_dark_d = row_d[0] ^ col_d[0];
      frame_busy_d  = yin_d | in_rows;
   end

   // Write arbiter. IDLE ignores requests during the ack cycle so a requester
   // that drops its request on seeing wr_ack does not start a phantom round.
   always_comb begin
      state_d   = state_q;
      store_we  = 1'b0;
      store_clr = 1'b0;
      wr_ack_d  = 1'b0;
      case (state_q)
         IDLE:   if ((clr_req || wr_req) && !wr_ack_q) state_d = WAIT;
         WAIT:   if (!frame_busy_q) state_d = COMMIT;
         COMMIT: begin
            state_d = IDLE;
            if (clr_req) begin
               store_clr = 1'b1;
               wr_ack_d  = 1'b1;
            end else if (wr_req) begin
               store_we = 1'b1;
               wr_ack_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         col_q         <= '0;
         offx_q        <= '0;
         xin_q         <= 1'b0;
         row_q         <= '0;
         offy_q        <= '0;
         yin_q         <= 1'b0;
         ybase_q       <= '0;
         sprite_sel_q  <= '0;
         sprite_addr_q <= '0;
         piece_on_q    <= 1'b0;
         board_on_q    <= 1'b0;
         square_dark_q <= 1'b0;
         frame_busy_q  <= 1'b0;
         wr_ack_q      <= 1'b0;
         state_q       <= IDLE;
      end else begin
         col_q         <= col_d;
         offx_q        <= offx_d;
         xin_q         <= xin_d;
         row_q         <= row_d;
         offy_q        <= offy_d;
         yin_q         <= yin_d;
         ybase_q       <= ybase_d;
         sprite_sel_q  <= sprite_sel_d;
         sprite_addr_q <= sprite_addr_d;
         piece_on_q    <= piece_on_d;
         board_on_q    <= board_on_d;
         square_dark_q <= square_dark_d;
         frame_busy_q  <= frame_busy_d;
         wr_ack_q      <= wr_ack_d;
         state_q       <= state_d;
      end
   end

   board_store u_store (
      .clk        (vga_clk),
      .load_start (reset | store_clr),
      .we         (store_we),
      .wr_addr    (wr_sq),
      .wr_data    (wr_piece),
      .rd_addr    ({row_d, col_d}),
      .rd_data    (rd_piece)
   );

   assign wr_ack      = wr_ack_q;
   assign sprite_sel  = sprite_sel_q;
   assign sprite_addr = sprite_addr_q;
   assign piece_on    = piece_on_q;
   assign board_on    = board_on_q;
   assign square_dark = square_dark_q;
   assign frame_busy  = frame_busy_q;

endmodule

// File: tb/tb_board_sprite_sched.sv
// Bench for board_sprite_sched: scans compressed frames, checks every pixel
// against a geometric reference model and exercises the write arbiter.
module tb_board_sprite_sched;

   logic        vga_clk = 1'b0;
   logic        reset;
   logic [9:0]  DrawX, DrawY;
   logic        wr_req, clr_req;
   logic [5:0]  wr_sq;
   logic [3:0]  wr_piece;
   logic        wr_ack;
   logic [3:0]  sprite_sel;
   logic [11:0] sprite_addr;
   logic        piece_on, board_on, square_dark, frame_busy;

   board_sprite_sched dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .wr_req      (wr_req),
      .wr_sq       (wr_sq),
      .wr_piece    (wr_piece),
      .clr_req     (clr_req),
      .wr_ack      (wr_ack),
      .sprite_sel  (sprite_sel),
      .sprite_addr (sprite_addr),
      .piece_on    (piece_on),
      .board_on    (board_on),
      .square_dark (square_dark),
      .frame_busy  (frame_busy)
   );

   always #5 vga_clk = ~vga_clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [3:0] start_tab [64];
   logic [3:0] mboard [64];
   int         m_line;
   bit         m_yok;
   int         n_ack, n0, ack_line;
   bit         prev_ack;
   bit         dir, dir2;
   int         scan_q[$];
   int         req_y, req_kind, rst_y;
   int         prev_row;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One pixel clock: drive beam, sample #1 after the edge, compare to model.
   task automatic cyc(input int x, input int y);
      int         r, c, addr;
      bit         yin, xin, on, busy;
      logic [3:0] sel;
      DrawX = 10'(x);
      DrawY = 10'(y);
      @(posedge vga_clk);
      #1;
      if (reset) begin
         mboard = start_tab;
         m_yok  = 1'b0;
      end else if (x == 0) begin
         m_line = y;
         if (y == 20) m_yok = 1'b1;
      end
      yin  = !reset && m_yok && m_line >= 20 && m_line <= 459;
      xin  = !reset && x >= 100 && x <= 539;
      on   = xin && yin;
      busy = !reset && (yin || (y >= 20 && y <= 459));
      sel  = 4'd0;
      addr = 0;
      r    = 0;
      c    = 0;
      if (on) begin
         r    = (m_line - 20) / 55;
         c    = (x - 100) / 55;
         sel  = mboard[r * 8 + c];
         addr = ((m_line - 20) % 55) * 55 + (x - 100) % 55;
      end
      chk("pix", {13'd0, board_on, piece_on, frame_busy, sprite_sel, sprite_addr},
                 {13'd0, on, (on && sel != 4'd0), busy, sel, 12'(addr)});
      if (on) chk("dark", 32'(square_dark), 32'((r + c) % 2));
      if (reset) chk("rst_out", {30'd0, wr_ack, square_dark}, 32'd0);
      if (dir) begin
         if (y == 20 && x == 100)
            chk("x100y20", {board_on, piece_on, square_dark, sprite_sel, sprite_addr},
                           {1'b1, 1'b1, 1'b0, 4'd10, 12'd0});
         if (y == 20 && x == 155) chk("x155", {square_dark, sprite_sel}, {1'b1, 4'd8});
         if (y == 20 && x == 540) chk("x540", {board_on, sprite_addr}, {1'b0, 12'd0});
         if (y == 74 && x == 154) chk("addr3024", 32'(sprite_addr), 32'd3024);
         if (y == 75 && x == 100) chk("row1", 32'(sprite_sel), 32'd7);
         if (y == 200 && x >= 100 && x < 540) chk("row3_empty", {board_on, piece_on}, 2'b10);
      end
      if (dir2 && y == 185 && x == 265) chk("sq27", 32'(sprite_sel), 32'd5);
      if (wr_ack) begin
         n_ack++;
         ack_line = y;
         chk("ack_req", 32'(clr_req || wr_req), 32'd1);
         chk("ack_pulse", 32'(prev_ack), 32'd0);
         chk("ack_blank", 32'(y <= 20 || y >= 460), 32'd1);
         if (clr_req) begin
            mboard  = start_tab;
            clr_req = 1'b0;
         end else if (wr_req) begin
            mboard[wr_sq] = wr_piece;
            wr_req        = 1'b0;
         end
      end
      prev_ack = wr_ack;
   endtask

   // 525-line frame; only lines in scan_q are scanned past the board edge.
   task automatic run_frame();
      for (int y = 0; y < 525; y++) begin
         int xmax;
         xmax = 1;
         foreach (scan_q[i]) if (scan_q[i] == y) xmax = 560;
         reset = (y == rst_y);
         if (reset) begin
            wr_req  = 1'b0;
            clr_req = 1'b0;
         end
         if (y == req_y) begin
            if (req_kind == 2) clr_req = 1'b1;
            wr_req = 1'b1;
         end
         for (int x = 0; x <= xmax; x++) cyc(x, y);
      end
      reset = 1'b0;
   endtask

   initial begin
      int back [8];
      back = '{10, 8, 9, 11, 12, 9, 8, 10};
      for (int i = 0; i < 64; i++) start_tab[i] = 4'd0;
      for (int i = 0; i < 8; i++) begin
         start_tab[i]      = 4'(back[i]);
         start_tab[8 + i]  = 4'd7;
         start_tab[48 + i] = 4'd1;
         start_tab[56 + i] = 4'(back[i] - 6);
      end
      mboard   = start_tab;
      reset    = 1'b1;
      DrawX    = '0;
      DrawY    = '0;
      wr_req   = 1'b0;
      clr_req  = 1'b0;
      wr_sq    = '0;
      wr_piece = '0;
      req_y    = -1;
      req_kind = 0;
      rst_y    = -1;
      dir      = 1'b0;
      dir2     = 1'b0;
      n_ack    = 0;
      ack_line = 0;
      prev_ack = 1'b0;
      m_line   = 0;
      m_yok    = 1'b0;

      for (int i = 0; i < 3; i++) cyc(0, 0);
      reset = 1'b0;

      // Start layout geometry plus a write requested mid-board.
      dir      = 1'b1;
      scan_q   = {20, 74, 75, 200};
      wr_sq    = 6'd27;
      wr_piece = 4'd5;
      req_kind = 1;
      req_y    = 100;
      n0       = n_ack;
      run_frame();
      chk("wr_one_ack", 32'(n_ack - n0), 32'd1);
      chk("wr_late", 32'(ack_line >= 460), 32'd1);
      dir   = 1'b0;
      req_y = -1;

      dir2   = 1'b1;
      scan_q = {185, 20 + $urandom_range(0, 439)};
      run_frame();
      dir2 = 1'b0;

      prev_row = 3;
      for (int k = 0; k < 4; k++) begin
         wr_sq    = 6'($urandom_range(0, 63));
         wr_piece = 4'($urandom_range(0, 15));
         req_y    = $urandom_range(0, 500);
         req_kind = 1;
         scan_q   = {20 + 55 * int'(wr_sq[5:3]) + $urandom_range(0, 54),
                     20 + 55 * prev_row + $urandom_range(0, 54),
                     20 + $urandom_range(0, 439)};
         prev_row = int'(wr_sq[5:3]);
         run_frame();
      end

      // Clear and write together during blank: clear first, write later.
      wr_sq    = 6'($urandom_range(16, 47));
      wr_piece = 4'($urandom_range(1, 12));
      req_kind = 2;
      req_y    = 470;
      scan_q   = {20 + 55 * prev_row + 7};
      n0       = n_ack;
      run_frame();
      chk("clr_two_acks", 32'(n_ack - n0), 32'd2);
      req_y    = -1;
      req_kind = 0;
      scan_q   = {30, 20 + 55 * int'(wr_sq[5:3]) + $urandom_range(0, 54),
                  20 + 385 + $urandom_range(0, 54)};
      run_frame();

      // Reset while the arbiter waits for blank.
      wr_sq    = 6'($urandom_range(16, 47));
      wr_piece = 4'($urandom_range(1, 12));
      req_kind = 1;
      req_y    = 100;
      rst_y    = 300;
      scan_q   = {20 + 55 * int'(wr_sq[5:3]) + 3};
      n0       = n_ack;
      run_frame();
      chk("rst_noack", 32'(n_ack - n0), 32'd0);
      rst_y = -1;
      req_y = -1;

      dir    = 1'b1;
      scan_q = {20, 74, 75, 200, 20 + 55 * int'(wr_sq[5:3]) + 5, 430};
      run_frame();
      dir = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/board_sprite_sched.md
Name: board_sprite_sched

Overview:
- Per-pixel scheduler for the chessboard display: one shared 55x55 piece sprite ROM serves all 64 squares.
- Tracks which board square and in-square offset the VGA beam is on, looks up the piece code from an internal 64-entry board store, and issues the sprite select and ROM address.
- Arbitrates board-store writes from game logic so that updates commit only while the beam is outside the board rows, which prevents tearing.
- Sits between the VGA controller / game FSM and the sprite ROM + palette datapath.

Parameters:
- BOARD_X0, 100, left pixel column of square (0,0)
- BOARD_Y0, 20, top pixel row of square (0,0)
- SQ, 55, square and sprite edge in pixels
- V_ACTIVE, 480, visible lines; DrawY >= V_ACTIVE is vertical blank

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column; advances by 1 per vga_clk within a line
- DrawY  in  10  current pixel row
- wr_req  in  1  game logic requests a board write; held until wr_ack
- wr_sq  in  6  target square {row[2:0], col[2:0]}
- wr_piece  in  4  piece code: 0 empty, 1-6 white P N B R Q K, 7-12 black P N B R Q K
- clr_req  in  1  request to reset the board to the start position; held until wr_ack
- wr_ack  out  1  one-cycle pulse when a write or clear commits
- sprite_sel  out  4  piece code of the current square
- sprite_addr  out  12  ROM address, equal to offx + offy*55
- piece_on  out  1  beam is on the board and the square is non-empty
- board_on  out  1  beam is inside the 440x440 board
- square_dark  out  1  (row+col) is odd
- frame_busy  out  1  beam is in the board rows, so writes are blocked

Behaviour:
- All outputs are registered on posedge vga_clk; latency is 1 cycle from DrawX/DrawY to outputs. Downstream ROM clocks on the negedge and the palette register on the posedge, as in the existing sprite path.
- Reset: all outputs 0. Board store loads the standard start position:
  - row 0: 10 8 9 11 12 9 8 10
  - row 1: all 7
  - rows 2-5: all 0
  - row 6: all 1
  - row 7: 4 2 3 5 6 3 2 4
- Column tracking (incremental counters, no divide):
  - On DrawX==BOARD_X0: col=0, offx=0, xin=1.
  - Else, while xin: offx increments; when offx reaches 54, it wraps to 0 and col increments.
  - When col would go past 7, xin drops.
- Row tracking: updated once per line on DrawX==0.
  - DrawY==BOARD_Y0: row=0, offy=0, yin=1.
  - Else, while yin: offy increments, wrapping at 54 to 0 with row increment.
  - When row would go past 7, yin drops.
  - DrawY >= V_ACTIVE forces yin=0.
- The offy*55 product is formed at line start as a registered line base, ybase = offy*55 (max 2970). The per-pixel address is ybase+offx, truncated to 12 bits; the maximum is 3024.
- board_on = xin & yin. sprite_sel = board[{row,col}] when board_on, else 0. piece_on = board_on & (sprite_sel != 0). sprite_addr = 0 when !board_on.
- frame_busy = yin, or DrawY in [BOARD_Y0, BOARD_Y0+439].
- Write arbiter FSM, states IDLE, WAIT, COMMIT:
  - IDLE: on clr_req or wr_req, go to WAIT.
  - WAIT: when !frame_busy, go to COMMIT.
  - COMMIT: write the store, pulse wr_ack for 1 cycle, return to IDLE.
  - If clr_req and wr_req are both high, clr has priority. The wr must stay asserted and is served in a later transaction.
  - The request is sampled in COMMIT. If the request was dropped before COMMIT, return to IDLE with no write and no ack.
  - The store update becomes visible on the cycle after COMMIT.
- Reset in any state returns the FSM to IDLE, and the store is reloaded.
- Codes 13-15 on wr_piece are written unchanged. The consumer treats them as empty.

Decomposition:
- chess_pkg holds:
  - typedef piece_t (4-bit enum, EMPTY..B_KING)
  - typedef sq_t (6-bit)
  - constants SQ_PX=55, BOARD_SQ=8
  - function start_piece(sq_t) returning the reset layout
- One sub-module, board_store: 64x4 register file with a combinational read port, a single write port, and a synchronous load_start.
- The beam trackers and the arbiter FSM live in board_sprite_sched.

Test Plan:
- Reset, then DrawX=100, DrawY=20 at line start → next cycle: board_on=1, sprite_sel=10, sprite_addr=0, square_dark=0, piece_on=1.
- Scan row 20, DrawX 100..540 → col steps every 55 px. At DrawX=155: sprite_sel=8, square_dark=1. At DrawX=540: board_on=0, sprite_addr=0.
- Line DrawY=74 (offy=54) at DrawX=154 → sprite_addr=3024. Line DrawY=75 → row=1, sprite_sel=7.
- DrawY=200 (row 3) → piece_on=0 across the board, while board_on=1.
- wr_req with wr_sq=27 and wr_piece=5 at DrawY=100 → no wr_ack until DrawY reaches 460. Then wr_ack is one pulse, and the next frame at row 3 col 3 shows sprite_sel=5.
- After writes, clr_req and wr_req asserted together during blank → clear commits first, with a single ack. The wr commits in a later ack. reset asserted mid-WAIT → FSM returns to IDLE, the start layout is restored, and no ack is produced.
